piso_serializer: RTL and testbench
==================================

Name: piso_serializer

Overview:
- Parallel-in serial-out stage that sits directly upstream of the 4-bit SISO shift register and drives its serial `din` input.
- Accepts a WIDTH-bit word through a valid/ready handshake, then emits it one bit per clock, with a per-bit valid and a last-bit marker.
- Supports back-to-back words with no idle gap between them, so the downstream shift register sees a continuous bitstream.

Parameters:
- WIDTH, 4, word width in bits; legal values are 2 or more.
- MSB_FIRST, 1, shift order: 1 = bit WIDTH-1 is sent first, 0 = bit 0 is sent first.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- data_in  input  WIDTH  parallel word to serialize.
- load_valid  input  1  data_in holds a word to be loaded.
- load_ready  output  1  serializer can accept a word this cycle.
- dout  output  1  serial bit; connects to the shift register's din.
- dout_valid  output  1  dout carries a valid data bit this cycle.
- last  output  1  the current dout bit is the final bit of the word.
- busy  output  1  a word is being shifted out.

Behaviour:
- State machine: two states, IDLE and SHIFT. Internal state is a WIDTH-bit shift register `sreg` and a bit counter `bit_cnt` of width clog2(WIDTH).
- Reset: while rst is sampled high, the next state is IDLE and sreg = 0, bit_cnt = 0.
  - Registered outputs after reset: dout = 0, dout_valid = 0, last = 0, busy = 0.
  - load_ready is combinational and forced to 0 while rst = 1.
- load_ready = !rst && (state == IDLE || (state == SHIFT && bit_cnt == WIDTH-1)).
- Accept: a word is accepted on a rising edge where load_valid = 1 and load_ready = 1.
  - On that edge, data_in is captured into sreg, bit_cnt is set to 0, and the state moves to SHIFT.
  - data_in is ignored after capture.
- Latency: the first bit appears on dout in the cycle after the accept edge. The word occupies exactly WIDTH consecutive cycles with dout_valid = 1.
- Bit order:
  - MSB_FIRST = 1: dout = sreg[WIDTH-1]; sreg shifts left each cycle with a 0 fill.
  - MSB_FIRST = 0: dout = sreg[0]; sreg shifts right each cycle with a 0 fill.
- SHIFT state:
  - Each rising edge advances bit_cnt by 1 and shifts sreg.
  - last = 1 exactly when bit_cnt == WIDTH-1.
  - busy = dout_valid = 1 throughout SHIFT.
- End of word, no new word accepted (bit_cnt == WIDTH-1 and no accept): the next state is IDLE, with dout = 0, dout_valid = 0, last = 0, busy = 0.
- Back-to-back (accept while bit_cnt == WIDTH-1): sreg reloads, bit_cnt = 0, and the state stays SHIFT. The next word's first bit follows the previous word's last bit with zero gap.
- IDLE outputs: dout = 0, dout_valid = 0, last = 0, busy = 0.
- load_valid while load_ready = 0: ignored. There is no buffering, and the word is not captured later.
- Reset mid-word: the current word is abandoned. On the next cycle the IDLE outputs are present, and no partial bits are emitted after reset.
- Simultaneous rst and load_valid: rst wins, and no word is captured.
- bit_cnt never exceeds WIDTH-1 and does not wrap inside SHIFT.

Test Plan:
- WIDTH = 4, MSB_FIRST = 1. Apply rst for 2 cycles, then load 4'b1011 → cycles 1–4 after accept show dout = 1,0,1,1 with dout_valid = 1; last = 1 only in cycle 4; cycle 5 shows dout_valid = 0, busy = 0, load_ready = 1.
- MSB_FIRST = 0, load 4'b1011 → dout = 1,1,0,1; last is set on the 4th bit.
- Back-to-back: load 4'b1011, then hold load_valid with 4'b0110 so it is accepted on the last-bit cycle → 8 contiguous valid bits 1,0,1,1,0,1,1,0; dout_valid never drops; last pulses on bits 4 and 8.
- Busy rejection: load 4'b1100; on bit 2, present 4'b0011 with load_valid = 1 → load_ready = 0, the word is ignored, and only 1,1,0,0 is emitted followed by idle.
- Reset mid-word: load 4'b1111 and assert rst after bit 2 → the next cycle has dout = 0, dout_valid = 0, busy = 0; afterwards, loading 4'b1010 serializes correctly as 1,0,1,0.
- Integration: drive dout into the 4-bit SISO shift register's din with MSB_FIRST = 1 and load 4'b1011 → one cycle after the last bit, the shift register's q holds 4'b1011 (order matching its shift direction) and q_bar = ~q.

Source files
------------

// File: rtl/piso_serializer.sv
// Parallel-in serial-out stage: accepts a WIDTH-bit word over valid/ready and emits it
// one bit per clock, with back-to-back words joined seamlessly on the last-bit cycle.
module piso_serializer #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             last,
  output logic             busy
);

  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic {
    StIdle,
    StShift
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  sreg_q, sreg_d;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic              in_shift;
  logic              at_end;
  logic              accept;

  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    bit_cnt_d = bit_cnt_q;

    in_shift   = (state_q == StShift);
    at_end     = in_shift && (bit_cnt_q == LastCnt);
    load_ready = !rst && ((state_q == StIdle) || at_end);
    accept     = load_valid && load_ready;

    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d   = StShift;
          sreg_d    = data_in;
          bit_cnt_d = '0;
        end
      end
      StShift: begin
        if (accept) begin
          // Reload on the last-bit cycle so the next word follows with no gap.
          sreg_d    = data_in;
          bit_cnt_d = '0;
        end else if (at_end) begin
          state_d   = StIdle;
          sreg_d    = '0;
          bit_cnt_d = '0;
        end else begin
          if (MSB_FIRST != 0) begin
            sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
          end else begin
            sreg_d = {1'b0, sreg_q[WIDTH-1:1]};
          end
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d   = StIdle;
        sreg_d    = '0;
        bit_cnt_d = '0;
      end
    endcase

    dout       = in_shift && ((MSB_FIRST != 0) ? sreg_q[WIDTH-1] : sreg_q[0]);
    dout_valid = in_shift;
    busy       = in_shift;
    last       = at_end;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      sreg_q    <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: one MSB-first and one LSB-first instance share stimulus;
// a small SISO shift-register model is fed from the MSB-first serial output.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] data_in;
  logic       load_valid;

  logic ready_m, dout_m, valid_m, last_m, busy_m;
  logic ready_l, dout_l, valid_l, last_l, busy_l;
  logic [3:0] siso_q;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1)) u_msb (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .load_valid (load_valid),
    .load_ready (ready_m),
    .dout       (dout_m),
    .dout_valid (valid_m),
    .last       (last_m),
    .busy       (busy_m)
  );

  piso_serializer #(.WIDTH(4), .MSB_FIRST(0)) u_lsb (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .load_valid (load_valid),
    .load_ready (ready_l),
    .dout       (dout_l),
    .dout_valid (valid_l),
    .last       (last_l),
    .busy       (busy_l)
  );

  // Downstream 4-bit SISO shift register, shifting toward the MSB.
  always_ff @(posedge clk) begin
    if (rst) siso_q <= '0;
    else     siso_q <= {siso_q[2:0], dout_m};
  end

  typedef struct {
    logic [3:0] word;
    logic [3:0] msb_stream;  // bit 3 is emitted first
    logic [3:0] lsb_stream;  // bit 3 is emitted first
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " m_valid"}, 32'(valid_m), 0);
    chk({tag, " m_busy"},  32'(busy_m),  0);
    chk({tag, " m_dout"},  32'(dout_m),  0);
    chk({tag, " m_last"},  32'(last_m),  0);
    chk({tag, " m_ready"}, 32'(ready_m), 32'(!rst));
    chk({tag, " l_valid"}, 32'(valid_l), 0);
    chk({tag, " l_ready"}, 32'(ready_l), 32'(!rst));
  endtask

  task automatic chk_bit(input string tag, input logic em, input logic el, input logic elast);
    chk({tag, " m_dout"},  32'(dout_m),  32'(em));
    chk({tag, " l_dout"},  32'(dout_l),  32'(el));
    chk({tag, " m_valid"}, 32'(valid_m), 1);
    chk({tag, " m_busy"},  32'(busy_m),  1);
    chk({tag, " m_last"},  32'(last_m),  32'(elast));
    chk({tag, " l_valid"}, 32'(valid_l), 1);
    chk({tag, " l_last"},  32'(last_l),  32'(elast));
  endtask

  // Entered just after a rising edge with both DUTs idle; leaves just after a rising edge.
  task automatic send_word(input vec_t v);
    data_in    = v.word;
    load_valid = 1'b1;
    @(negedge clk);
    chk("accept ready", 32'(ready_m), 1);
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    data_in    = 4'h0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_bit("word bit", v.msb_stream[3-i], v.lsb_stream[3-i], i == 3);
    end
    @(negedge clk);
    chk_idle("after word");
    chk("siso q", 32'(siso_q), 32'(v.msb_stream));
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] b2b;
    vecs[0] = '{word: 4'b1011, msb_stream: 4'b1011, lsb_stream: 4'b1101};
    vecs[1] = '{word: 4'b1100, msb_stream: 4'b1100, lsb_stream: 4'b0011};
    vecs[2] = '{word: 4'b0110, msb_stream: 4'b0110, lsb_stream: 4'b0110};
    vecs[3] = '{word: 4'b1000, msb_stream: 4'b1000, lsb_stream: 4'b0001};
    vecs[4] = '{word: 4'b0111, msb_stream: 4'b0111, lsb_stream: 4'b1110};

    rst        = 1'b1;
    data_in    = 4'b1111;
    load_valid = 1'b1;
    @(posedge clk);
    #1;
    chk_idle("in reset");
    @(posedge clk);
    #1;
    chk_idle("in reset 2");
    rst        = 1'b0;
    load_valid = 1'b0;
    @(negedge clk);
    chk_idle("post reset");
    @(posedge clk);
    #1;

    foreach (vecs[k]) send_word(vecs[k]);

    // Back-to-back: second word held on load_valid is taken on the last-bit cycle.
    b2b        = 8'b1011_0110;
    data_in    = 4'b1011;
    load_valid = 1'b1;
    @(posedge clk);
    #1;
    data_in = 4'b0110;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("b2b dout",  32'(dout_m),  32'(b2b[7-i]));
      chk("b2b valid", 32'(valid_m), 1);
      chk("b2b last",  32'(last_m),  32'(i == 3 || i == 7));
      chk("b2b ready", 32'(ready_m), 32'(i == 3 || i == 7));
      if (i == 3) begin
        @(posedge clk);
        #1;
        load_valid = 1'b0;
      end
    end
    @(negedge clk);
    chk_idle("b2b end");
    @(posedge clk);
    #1;

    // Busy rejection: a word offered mid-shift is dropped.
    data_in    = 4'b1100;
    load_valid = 1'b1;
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    @(negedge clk);
    chk_bit("rej bit1", 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    data_in    = 4'b0011;
    load_valid = 1'b1;
    @(negedge clk);
    chk("rej ready m", 32'(ready_m), 0);
    chk("rej ready l", 32'(ready_l), 0);
    chk_bit("rej bit2", 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    @(negedge clk);
    chk_bit("rej bit3", 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk_bit("rej bit4", 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    chk_idle("rej idle1");
    @(negedge clk);
    chk_idle("rej idle2");
    @(posedge clk);
    #1;

    // Reset mid-word, with load_valid asserted alongside rst.
    data_in    = 4'b1111;
    load_valid = 1'b1;
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    @(negedge clk);
    chk_bit("rst bit1", 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk_bit("rst bit2", 1'b1, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    rst        = 1'b1;
    data_in    = 4'b0101;
    load_valid = 1'b1;
    @(negedge clk);
    chk("rst ready forced", 32'(ready_m), 0);
    @(posedge clk);
    #1;
    rst        = 1'b0;
    load_valid = 1'b0;
    @(negedge clk);
    chk_idle("after mid rst");
    @(negedge clk);
    chk_idle("after mid rst 2");
    @(posedge clk);
    #1;
    send_word('{word: 4'b1010, msb_stream: 4'b1010, lsb_stream: 4'b0101});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: run did not complete");
    $fatal(1, "timeout");
  end

endmodule
